// File: rtl/hazard_ctrl_pkg.sv
// Shared definitions for the hazard controller: FSM state encoding,
// the hard-wired zero register index and the watchdog default.
package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [4:0] REG_X0       = 5'd0;
  localparam int         WDOG_MAX_DEF = 255;

  // A producer satisfies a consumer source when the source is really read,
  // is not x0, and the producer writes that same register.
  function automatic logic src_hit(input logic       i_re,
                                   input logic [4:0] i_rr,
                                   input logic       i_we,
                                   input logic [4:0] i_wr);
    return i_re && (i_rr != REG_X0) && i_we && (i_wr == i_rr);
  endfunction

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Per-operand forward selection: picks the youngest producer holding the
// value for one ID-stage source. A load in EX has no data yet, so it never
// wins; its raw match is still exported for load-use detection.
module fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic        i_re,
  input  logic [4:0]  i_rr,
  input  logic [4:0]  i_ex_wr,
  input  logic        i_ex_we,
  input  logic        i_ex_is_load,
  input  logic [31:0] i_ex_res,
  input  logic [4:0]  i_mem_wr,
  input  logic        i_mem_we,
  input  logic [31:0] i_mem_wd,
  input  logic [4:0]  i_wb_wr,
  input  logic        i_wb_we,
  input  logic [31:0] i_wb_wd,
  output logic        o_sel,
  output logic [31:0] o_fwd,
  output logic        o_ex_hit
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_ex_hit  = src_hit(i_re, i_rr, i_ex_we,  i_ex_wr);
  assign w_mem_hit = src_hit(i_re, i_rr, i_mem_we, i_mem_wr);
  assign w_wb_hit  = src_hit(i_re, i_rr, i_wb_we,  i_wb_wr);
  assign o_ex_hit  = w_ex_hit;

  // Priority mux: EX (non-load) over MEM over WB.
  always_comb begin
    o_sel = 1'b0;
    o_fwd = '0;
    if (w_ex_hit && !i_ex_is_load) begin
      o_sel = 1'b1;
      o_fwd = i_ex_res;
    end else if (w_mem_hit) begin
      o_sel = 1'b1;
      o_fwd = i_mem_wd;
    end else if (w_wb_hit) begin
      o_sel = 1'b1;
      o_fwd = i_wb_wd;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch
// redirect flush and DRAM wait stall with a sticky watchdog timeout.
// Optional build macro HAZARD_PERF_CNT_EN adds stall_cnt/flush_cnt.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   ST_RUN      | normal flow; forwarding, load-use and redirect active
//   ST_MEM_WAIT | DRAM access pending; whole front end frozen
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int WDOG_MAX = WDOG_MAX_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  id_rR1,
  input  logic [4:0]  id_rR2,
  input  logic        id_re1,
  input  logic        id_re2,
  input  logic [4:0]  ex_wR,
  input  logic        ex_rf_we,
  input  logic        ex_is_load,
  input  logic [31:0] ex_res,
  input  logic [4:0]  mem_wR,
  input  logic        mem_rf_we,
  input  logic [31:0] mem_wd,
  input  logic [4:0]  wb_wR,
  input  logic        wb_rf_we,
  input  logic [31:0] wb_wd,
  input  logic        ex_redirect,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idex,
  output logic        stall_exmem,
  output logic        flush_ifid,
  output logic        flush_idex,
  output logic        rD1_sel,
  output logic        rD2_sel,
  output logic [31:0] rD1_forward,
  output logic [31:0] rD2_forward,
  output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  localparam int WW = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX + 1);

  state_t        r_state;
  logic [WW-1:0] r_wdog;
  logic          r_timeout;

  logic          w_run;
  logic          w_load_use;
  logic          w_sel1;
  logic          w_sel2;
  logic [31:0]   w_fwd1;
  logic [31:0]   w_fwd2;
  logic          w_ex_hit1;
  logic          w_ex_hit2;

  fwd_sel u_fwd1 (
    .i_re         (id_re1),
    .i_rr         (id_rR1),
    .i_ex_wr      (ex_wR),
    .i_ex_we      (ex_rf_we),
    .i_ex_is_load (ex_is_load),
    .i_ex_res     (ex_res),
    .i_mem_wr     (mem_wR),
    .i_mem_we     (mem_rf_we),
    .i_mem_wd     (mem_wd),
    .i_wb_wr      (wb_wR),
    .i_wb_we      (wb_rf_we),
    .i_wb_wd      (wb_wd),
    .o_sel        (w_sel1),
    .o_fwd        (w_fwd1),
    .o_ex_hit     (w_ex_hit1)
  );

  fwd_sel u_fwd2 (
    .i_re         (id_re2),
    .i_rr         (id_rR2),
    .i_ex_wr      (ex_wR),
    .i_ex_we      (ex_rf_we),
    .i_ex_is_load (ex_is_load),
    .i_ex_res     (ex_res),
    .i_mem_wr     (mem_wR),
    .i_mem_we     (mem_rf_we),
    .i_mem_wd     (mem_wd),
    .i_wb_wr      (wb_wR),
    .i_wb_we      (wb_rf_we),
    .i_wb_wd      (wb_wd),
    .o_sel        (w_sel2),
    .o_fwd        (w_fwd2),
    .o_ex_hit     (w_ex_hit2)
  );

  assign w_run       = (r_state == ST_RUN);
  assign w_load_use  = ex_is_load && (w_ex_hit1 || w_ex_hit2);
  assign mem_timeout = r_timeout;

  // Forwarding is suppressed while frozen; the held ID/EX register must not
  // capture stale bypass data.
  assign rD1_sel     = w_run && w_sel1;
  assign rD2_sel     = w_run && w_sel2;
  assign rD1_forward = w_run ? w_fwd1 : '0;
  assign rD2_forward = w_run ? w_fwd2 : '0;

  // State, watchdog down-counter and sticky timeout flag. The watchdog is
  // loaded on entry to MEM_WAIT so that terminal count 0 marks the
  // WDOG_MAX-th wait cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_wdog    <= '0;
      r_timeout <= 1'b0;
    end else begin
      case (r_state)
        ST_RUN: begin
          r_wdog <= '0;
          if (mem_req && !mem_ready) begin
            r_state <= ST_MEM_WAIT;
            r_wdog  <= WW'(WDOG_MAX - 1);
          end
        end
        ST_MEM_WAIT: begin
          if (mem_ready) begin
            r_state <= ST_RUN;
            r_wdog  <= '0;
          end else if (r_wdog == '0) begin
            r_state   <= ST_RUN;
            r_timeout <= 1'b1;
          end else begin
            r_wdog <= r_wdog - 1'b1;
          end
        end
        default: begin
          r_state <= ST_RUN;
          r_wdog  <= '0;
        end
      endcase
    end
  end

  // Pipeline controls; redirect outranks load-use, and while waiting on
  // memory both are ignored because the frozen inputs replay them later.
  always_comb begin
    stall_pc    = 1'b0;
    stall_ifid  = 1'b0;
    stall_idex  = 1'b0;
    stall_exmem = 1'b0;
    flush_ifid  = 1'b0;
    flush_idex  = 1'b0;
    if (!w_run) begin
      stall_pc    = 1'b1;
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
    end else if (ex_redirect) begin
      flush_ifid = 1'b1;
      flush_idex = 1'b1;
    end else if (w_load_use) begin
      stall_pc   = 1'b1;
      stall_ifid = 1'b1;
      flush_idex = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  // Free-running wrap-around event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_pc)   r_stall_cnt <= r_stall_cnt + 32'd1;
      if (flush_idex) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with WDOG_MAX=4.
module tb_hazard_ctrl;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rR1, id_rR2;
  logic        id_re1, id_re2;
  logic [4:0]  ex_wR;
  logic        ex_rf_we, ex_is_load;
  logic [31:0] ex_res;
  logic [4:0]  mem_wR;
  logic        mem_rf_we;
  logic [31:0] mem_wd;
  logic [4:0]  wb_wR;
  logic        wb_rf_we;
  logic [31:0] wb_wd;
  logic        ex_redirect, mem_req, mem_ready;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic        flush_ifid, flush_idex;
  logic        rD1_sel, rD2_sel;
  logic [31:0] rD1_forward, rD2_forward;
  logic        mem_timeout;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  logic [5:0]  ctrl;
  int          n_total;
  int          n_bad;
  int          exp_st;
  int          exp_fl;

  assign ctrl = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex};

  hazard_ctrl #(.WDOG_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .id_rR1      (id_rR1),
    .id_rR2      (id_rR2),
    .id_re1      (id_re1),
    .id_re2      (id_re2),
    .ex_wR       (ex_wR),
    .ex_rf_we    (ex_rf_we),
    .ex_is_load  (ex_is_load),
    .ex_res      (ex_res),
    .mem_wR      (mem_wR),
    .mem_rf_we   (mem_rf_we),
    .mem_wd      (mem_wd),
    .wb_wR       (wb_wR),
    .wb_rf_we    (wb_rf_we),
    .wb_wd       (wb_wd),
    .ex_redirect (ex_redirect),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .stall_pc    (stall_pc),
    .stall_ifid  (stall_ifid),
    .stall_idex  (stall_idex),
    .stall_exmem (stall_exmem),
    .flush_ifid  (flush_ifid),
    .flush_idex  (flush_idex),
    .rD1_sel     (rD1_sel),
    .rD2_sel     (rD2_sel),
    .rD1_forward (rD1_forward),
    .rD2_forward (rD2_forward),
    .mem_timeout (mem_timeout)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Checks this cycle's controls; expected event counts accumulate from
  // the expected vectors, so the counters are compared before adding now.
  task automatic step(input string tag, input logic [5:0] exp);
    check(tag, {26'd0, ctrl}, {26'd0, exp});
`ifdef HAZARD_PERF_CNT_EN
    check({tag, "_scnt"}, stall_cnt, exp_st);
    check({tag, "_fcnt"}, flush_cnt, exp_fl);
`endif
    exp_st += int'(exp[5]);
    exp_fl += int'(exp[0]);
  endtask

  task automatic clr();
    id_rR1 = 0; id_rR2 = 0; id_re1 = 0; id_re2 = 0;
    ex_wR = 0; ex_rf_we = 0; ex_is_load = 0; ex_res = 0;
    mem_wR = 0; mem_rf_we = 0; mem_wd = 0;
    wb_wR = 0; wb_rf_we = 0; wb_wd = 0;
    ex_redirect = 0; mem_req = 0; mem_ready = 0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0; n_bad = 0; exp_st = 0; exp_fl = 0;
    clr();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {26'd0, ctrl}, 32'd0);
    check("rst_to", {31'd0, mem_timeout}, 32'd0);
    check("rst_sel", {30'd0, rD1_sel, rD2_sel}, 32'd0);
    ex_redirect = 1'b1;
    #1 check("rst_live_redirect", {26'd0, ctrl}, 32'b000011);
    ex_redirect = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    // Case A: EX beats MEM, then MEM, then WB, then no read
    next();
    ex_wR = 5; ex_rf_we = 1; ex_res = 32'h11;
    mem_wR = 5; mem_rf_we = 1; mem_wd = 32'h22;
    wb_wR = 5; wb_rf_we = 1; wb_wd = 32'h33;
    id_rR1 = 5; id_re1 = 1;
    @(negedge clk);
    step("A_ctrl", 6'b000000);
    check("A_sel", {31'd0, rD1_sel}, 32'd1);
    check("A_fwd", rD1_forward, 32'h11);
    check("A_sel2", {31'd0, rD2_sel}, 32'd0);
    next(); ex_rf_we = 0;
    @(negedge clk);
    step("A2_ctrl", 6'b000000);
    check("A2_fwd_mem", rD1_forward, 32'h22);
    next(); mem_rf_we = 0;
    @(negedge clk);
    step("A3_ctrl", 6'b000000);
    check("A3_fwd_wb", rD1_forward, 32'h33);
    next(); id_re1 = 0;
    @(negedge clk);
    step("A4_ctrl", 6'b000000);
    check("A4_sel", {31'd0, rD1_sel}, 32'd0);
    check("A4_fwd", rD1_forward, 32'd0);

    // Case B: load-use on source 2, then MEM forwards
    next(); clr();
    ex_wR = 7; ex_rf_we = 1; ex_is_load = 1; ex_res = 32'hdead;
    id_rR2 = 7; id_re2 = 1;
    @(negedge clk);
    step("B_lu_ctrl", 6'b110001);
    check("B_lu_sel", {31'd0, rD2_sel}, 32'd0);
    next();
    ex_rf_we = 0; ex_is_load = 0;
    mem_wR = 7; mem_rf_we = 1; mem_wd = 32'h77;
    @(negedge clk);
    step("B_fw_ctrl", 6'b000000);
    check("B_fw_sel", {31'd0, rD2_sel}, 32'd1);
    check("B_fw_data", rD2_forward, 32'h77);

    // Load in EX never forwards; MEM with same reg does, stall still raised
    next();
    ex_wR = 7; ex_rf_we = 1; ex_is_load = 1; mem_wd = 32'h55;
    @(negedge clk);
    step("B2_ctrl", 6'b110001);
    check("B2_fwd_mem", rD2_forward, 32'h55);

    // Case C: redirect overrides load-use
    next(); ex_redirect = 1;
    @(negedge clk);
    step("C_ctrl", 6'b000011);

    // Case F: x0 never forwards
    next(); clr();
    id_rR1 = 0; id_re1 = 1;
    ex_wR = 0; ex_rf_we = 1; ex_res = 32'h99;
    mem_wR = 0; mem_rf_we = 1; mem_wd = 32'h98;
    wb_wR = 0; wb_rf_we = 1; wb_wd = 32'h97;
    @(negedge clk);
    step("F_ctrl", 6'b000000);
    check("F_sel", {31'd0, rD1_sel}, 32'd0);
    check("F_fwd", rD1_forward, 32'd0);

    // Case D: ready low three cycles, redirect deferred out of MEM_WAIT
    next(); clr(); mem_req = 1;
    @(negedge clk);
    step("D0_run", 6'b000000);
    next();
    @(negedge clk);
    step("D1_wait", 6'b111100);
    next();
    ex_redirect = 1; ex_wR = 5; ex_rf_we = 1; ex_res = 32'h44; id_rR1 = 5; id_re1 = 1;
    @(negedge clk);
    step("D2_wait_redir", 6'b111100);
    check("D2_sel", {31'd0, rD1_sel}, 32'd0);
    next(); mem_ready = 1;
    @(negedge clk);
    step("D3_wait_ready", 6'b111100);
    next(); mem_req = 0; mem_ready = 0;
    @(negedge clk);
    step("D4_run_redir", 6'b000011);
    check("D4_sel", {31'd0, rD1_sel}, 32'd1);
    check("D4_fwd", rD1_forward, 32'h44);
    next(); clr(); mem_req = 1; mem_ready = 1;
    @(negedge clk);
    step("D5_ready_now", 6'b000000);
    next();
    @(negedge clk);
    step("D6_no_wait", 6'b000000);

    // Case E: ready never comes, watchdog fires after 4 wait cycles
    next(); clr(); mem_req = 1;
    @(negedge clk);
    step("E0_run", 6'b000000);
    for (int i = 1; i <= 4; i++) begin
      next();
      @(negedge clk);
      step($sformatf("E%0d_wait", i), 6'b111100);
      check($sformatf("E%0d_to", i), {31'd0, mem_timeout}, 32'd0);
    end
    next(); mem_req = 0;
    @(negedge clk);
    step("E5_run", 6'b000000);
    check("E5_to", {31'd0, mem_timeout}, 32'd1);
    next(); mem_req = 1;
    @(negedge clk);
    step("E6_run", 6'b000000);
    check("E6_to_sticky", {31'd0, mem_timeout}, 32'd1);
    next();
    @(negedge clk);
    step("E7_wait", 6'b111100);
    rst_n = 1'b0;
    #1;
    check("E_rst_ctrl", {26'd0, ctrl}, 32'd0);
    check("E_rst_to", {31'd0, mem_timeout}, 32'd0);
`ifdef HAZARD_PERF_CNT_EN
    check("E_rst_scnt", stall_cnt, 32'd0);
    check("E_rst_fcnt", flush_cnt, 32'd0);
`endif
    exp_st = 0; exp_fl = 0;
    mem_req = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    next();
    @(negedge clk);
    step("E_post_ctrl", 6'b000000);
    check("E_post_to", {31'd0, mem_timeout}, 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; rst_n in 1, asynchronous active-low reset.
REQ-002 SHALL have ports: id_rR1, id_rR2 in 5 each, ID-stage source register numbers; id_re1, id_re2 in 1 each, ID instruction reads that source.
REQ-003 SHALL have ports: ex_wR in 5, ex_rf_we in 1, ex_is_load in 1, ex_res in 32; this is the EX-stage producer.
REQ-004 SHALL have ports: mem_wR in 5, mem_rf_we in 1, mem_wd in 32; wb_wR in 5, wb_rf_we in 1, wb_wd in 32; these are the MEM and WB producers.
REQ-005 SHALL have ports: ex_redirect in 1, taken branch or jump resolved in EX; mem_req in 1, mem_ready in 1, DRAM access handshake.
REQ-006 SHALL have ports: stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex out 1 each, pipeline register controls.
REQ-007 SHALL have ports: rD1_sel, rD2_sel out 1 each; rD1_forward, rD2_forward out 32 each, forwarding controls into the ID/EX register.
REQ-008 SHALL have port mem_timeout out 1, sticky watchdog flag.
REQ-009 SHALL have parameter WDOG_MAX, default 255, maximum MEM_WAIT cycles before timeout.

Function
REQ-010 SHALL hold the FSM in state RUN or MEM_WAIT; all pipeline control outputs SHALL be combinational from state and inputs.
REQ-011 Forward match for source n SHALL require id_ren=1, id_rRn!=0 and producer rf_we=1 with producer wR==id_rRn.
REQ-012 Forward priority SHALL be EX (only when ex_is_load=0) > MEM > WB; rDn_forward SHALL be the winning data and rDn_sel=1; with no match, rDn_sel=0 and rDn_forward=0.
REQ-013 Load-use: in RUN, when ex_is_load=1 and an EX match exists on either source, stall_pc=stall_ifid=1 and flush_idex=1 for that cycle.
REQ-014 Redirect: in RUN, when ex_redirect=1, flush_ifid=flush_idex=1 and stall_pc=0; redirect SHALL override load-use in the same cycle.
REQ-015 RUN->MEM_WAIT when mem_req=1 and mem_ready=0; in MEM_WAIT all four stall outputs =1, both flushes =0, and rDn_sel=0.
REQ-016 MEM_WAIT->RUN in the cycle after mem_ready=1; mem_req=1 with mem_ready=1 in RUN SHALL cause no stall.
REQ-017 A redirect or load-use asserted during MEM_WAIT SHALL be deferred until the first RUN cycle; inputs are frozen by the stalls, so the event reappears there.
REQ-018 The watchdog counter SHALL count MEM_WAIT cycles and clear on entry to RUN; reaching WDOG_MAX SHALL set mem_timeout and force RUN. mem_timeout SHALL clear only on reset.

Reset
REQ-019 rst_n=0 SHALL asynchronously force state RUN, clear the watchdog counter and clear mem_timeout; all outputs then follow RUN with live inputs.
REQ-020 Reset mid-MEM_WAIT SHALL release all stalls immediately, without waiting for a clock edge.

Configuration
REQ-021 With macro HAZARD_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt and flush_cnt, 32 bits each, wrapping.
REQ-022 stall_cnt SHALL increment on each cycle with stall_pc=1, and flush_cnt on each cycle with flush_idex=1; both SHALL clear on reset.
REQ-023 Without HAZARD_PERF_CNT_EN, the counter ports and registers SHALL be absent; all other behaviour is identical.

Structure
REQ-024 FSM state encodings, the x0 register index and the WDOG_MAX default SHALL live in the shared param package.
REQ-025 Forward selection SHALL be a sub-module fwd_sel, instantiated once per source operand.

Verification
REQ-026 Case A: EX x5 non-load producing 0x11, MEM x5 producing 0x22, ID reads rR1=5 -> rD1_sel=1, rD1_forward=0x11.
REQ-027 Case B: EX load to x7, ID rR2=7 -> one cycle of stall_pc=stall_ifid=flush_idex=1; next cycle MEM forwards, rD2_sel=1.
REQ-028 Case C: load-use and ex_redirect in the same cycle -> flush_ifid=flush_idex=1, stall_pc=0.
REQ-029 Case D: mem_req=1 with mem_ready low for 3 cycles -> 3 cycles MEM_WAIT with all stalls=1, RUN on the cycle after ready.
REQ-030 Case E: mem_ready never asserted, WDOG_MAX=4 -> mem_timeout=1 after 4 cycles, back to RUN; rst_n pulse clears mem_timeout.
REQ-031 Case F: ID rR1=0 with any producer wR=0 -> rD1_sel=0; with the macro defined, the counters match the stall and flush cycle counts.
